// File: rtl/issue_queue_pkg.sv
`default_nettype none
// ============================================================================
// Module      : issue_queue_pkg
// Description : Shared widths, entry/wakeup types and tag-match helper for
//               the out-of-order issue queue.
// Revision    : 1.0 - initial release
// ============================================================================
package issue_queue_pkg;

    localparam int IQ_DEPTH  = 16;
    localparam int TAG_W     = 6;
    localparam int BR_CNT    = 8;
    localparam int PAYLOAD_W = 64;
    localparam int BR_ID_W   = $clog2(BR_CNT);
    localparam int CNT_W     = $clog2(IQ_DEPTH) + 1;

    typedef struct packed {
        logic             valid;
        logic [TAG_W-1:0] tag;
    } wakeup_t;

    typedef struct packed {
        logic                 valid;
        logic                 rdy1;
        logic                 rdy2;
        logic [TAG_W-1:0]     src1;
        logic [TAG_W-1:0]     src2;
        logic [TAG_W-1:0]     dst;
        logic [BR_CNT-1:0]    br_mask;
        logic [PAYLOAD_W-1:0] payload;
    } iq_entry_t;

    function automatic logic tag_woken(input wakeup_t [1:0] wk, input logic [TAG_W-1:0] tag);
        return (wk[0].valid && (wk[0].tag == tag)) || (wk[1].valid && (wk[1].tag == tag));
    endfunction

endpackage
`default_nettype wire

// File: rtl/issue_queue_if.sv
`default_nettype none
// ============================================================================
// Module      : issue_queue_if
// Description : Enqueue, wakeup, branch and issue signals of the issue queue.
// Revision    : 1.0 - initial release
// ============================================================================
interface issue_queue_if;
    import issue_queue_pkg::*;

    logic                 enq_valid;
    logic                 enq_flush;
    logic [PAYLOAD_W-1:0] enq_payload;
    logic [TAG_W-1:0]     enq_src1;
    logic [TAG_W-1:0]     enq_src2;
    logic                 enq_rdy1;
    logic                 enq_rdy2;
    logic [TAG_W-1:0]     enq_dst;
    logic [BR_CNT-1:0]    enq_br_mask;
    logic                 iq_full;
    wakeup_t [1:0]        wk;
    logic                 br_miss;
    logic                 br_resolve;
    logic [BR_ID_W-1:0]   br_id;
    logic                 iss_valid;
    logic                 iss_ready;
    logic [PAYLOAD_W-1:0] iss_payload;
    logic [TAG_W-1:0]     iss_src1;
    logic [TAG_W-1:0]     iss_src2;
    logic [TAG_W-1:0]     iss_dst;
    logic [BR_CNT-1:0]    iss_br_mask;
    logic [CNT_W-1:0]     iq_count;

    modport master (
        output enq_valid, enq_flush, enq_payload, enq_src1, enq_src2, enq_rdy1, enq_rdy2,
               enq_dst, enq_br_mask, wk, br_miss, br_resolve, br_id, iss_ready,
        input  iq_full, iss_valid, iss_payload, iss_src1, iss_src2, iss_dst, iss_br_mask, iq_count
    );

    modport slave (
        input  enq_valid, enq_flush, enq_payload, enq_src1, enq_src2, enq_rdy1, enq_rdy2,
               enq_dst, enq_br_mask, wk, br_miss, br_resolve, br_id, iss_ready,
        output iq_full, iss_valid, iss_payload, iss_src1, iss_src2, iss_dst, iss_br_mask, iq_count
    );

endinterface
`default_nettype wire

// File: rtl/issue_queue_age_matrix.sv
`default_nettype none
// ============================================================================
// Module      : iq_age_matrix
// Description : Age matrix; row i bit j set means entry i is older than j.
//               Grants the oldest requesting entry one-hot.
// Revision    : 1.0 - initial release
// ============================================================================
module iq_age_matrix #(
    parameter int DEPTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [DEPTH-1:0] alloc_i,
    input  logic [DEPTH-1:0] free_i,
    input  logic [DEPTH-1:0] req_i,
    output logic [DEPTH-1:0] grant_o
);
    logic [DEPTH-1:0] older_q [DEPTH];

    // A new entry is older than nobody, and every other entry is older than it.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) older_q[i] <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                for (int j = 0; j < DEPTH; j++) begin
                    if (alloc_i[i])                 older_q[i][j] <= 1'b0;
                    else if (alloc_i[j])            older_q[i][j] <= 1'b1;
                    else if (free_i[i] || free_i[j]) older_q[i][j] <= 1'b0;
                end
            end
        end
    end

    for (genvar i = 0; i < DEPTH; i++) begin : g_grant
        logic [DEPTH-1:0] older_than_i;
        for (genvar j = 0; j < DEPTH; j++) begin : g_col
            assign older_than_i[j] = older_q[j][i];
        end
        assign grant_o[i] = req_i[i] & ~|(req_i & older_than_i);
    end

endmodule
`default_nettype wire

// File: rtl/issue_queue.sv
`default_nettype none
// ============================================================================
// Module      : issue_queue
// Description : Out-of-order issue queue: CAM wakeup, oldest-ready select,
//               branch-mask kill and registered occupancy.
// Revision    : 1.0 - initial release
// ============================================================================
module issue_queue
    import issue_queue_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    issue_queue_if.slave iq
);
    iq_entry_t           ent_q [IQ_DEPTH];
    iq_entry_t           ent_d [IQ_DEPTH];
    iq_entry_t           new_ent;
    iq_entry_t           sel;
    logic [CNT_W-1:0]    count_q, count_d;
    logic                full_q;
    logic [IQ_DEPTH-1:0] req, grant, kill, free_oh, alloc_oh, release_mask;
    logic [BR_CNT-1:0]   clr_mask;
    logic                enq_acc, iss_kill, iss_valid, deq, slot_found;
    int                  kill_cnt, count_calc;

    assign enq_acc  = iq.enq_valid & ~iq.enq_flush & ~iq.br_miss & ~full_q;
    assign clr_mask = (iq.br_resolve & ~iq.br_miss) ? (BR_CNT'(1) << iq.br_id) : '0;

    always_comb begin
        req        = '0;
        kill       = '0;
        free_oh    = '0;
        slot_found = 1'b0;
        for (int i = 0; i < IQ_DEPTH; i++) begin
            req[i]  = ent_q[i].valid & ent_q[i].rdy1 & ent_q[i].rdy2;
            kill[i] = iq.br_miss & ent_q[i].valid & ent_q[i].br_mask[iq.br_id];
            if (!ent_q[i].valid && !slot_found) begin
                free_oh[i] = 1'b1;
                slot_found = 1'b1;
            end
        end
    end

    assign alloc_oh     = enq_acc ? free_oh : '0;
    assign release_mask = kill | (deq ? grant : '0);

    iq_age_matrix #(.DEPTH(IQ_DEPTH)) u_age (
        .clk     (clk),
        .rst     (rst),
        .alloc_i (alloc_oh),
        .free_i  (release_mask),
        .req_i   (req),
        .grant_o (grant)
    );

    always_comb begin
        sel = '0;
        for (int i = 0; i < IQ_DEPTH; i++) begin
            if (grant[i]) sel = ent_q[i];
        end
    end

    // A selected uop being killed this cycle must not be handed to execute.
    assign iss_kill  = iq.br_miss & sel.br_mask[iq.br_id];
    assign iss_valid = sel.valid & sel.rdy1 & sel.rdy2 & ~iss_kill;
    assign deq       = iss_valid & iq.iss_ready;

    always_comb begin
        new_ent.valid   = 1'b1;
        new_ent.rdy1    = iq.enq_rdy1 | tag_woken(iq.wk, iq.enq_src1);
        new_ent.rdy2    = iq.enq_rdy2 | tag_woken(iq.wk, iq.enq_src2);
        new_ent.src1    = iq.enq_src1;
        new_ent.src2    = iq.enq_src2;
        new_ent.dst     = iq.enq_dst;
        new_ent.br_mask = iq.enq_br_mask & ~clr_mask;
        new_ent.payload = iq.enq_payload;
    end

    always_comb begin
        for (int i = 0; i < IQ_DEPTH; i++) begin
            ent_d[i] = ent_q[i];
            if (alloc_oh[i]) begin
                ent_d[i] = new_ent;
            end else if (kill[i] || (deq && grant[i])) begin
                ent_d[i].valid = 1'b0;
            end else begin
                ent_d[i].rdy1    = ent_q[i].rdy1 | tag_woken(iq.wk, ent_q[i].src1);
                ent_d[i].rdy2    = ent_q[i].rdy2 | tag_woken(iq.wk, ent_q[i].src2);
                ent_d[i].br_mask = ent_q[i].br_mask & ~clr_mask;
            end
        end
    end

    always_comb begin
        kill_cnt = 0;
        for (int i = 0; i < IQ_DEPTH; i++) kill_cnt = kill_cnt + (kill[i] ? 1 : 0);
        count_calc = int'(count_q) + (enq_acc ? 1 : 0) - (deq ? 1 : 0) - kill_cnt;
        count_d    = count_calc[CNT_W-1:0];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < IQ_DEPTH; i++) ent_q[i] <= '0;
            count_q <= '0;
            full_q  <= 1'b0;
        end else begin
            ent_q   <= ent_d;
            count_q <= count_d;
            full_q  <= (count_d == CNT_W'(IQ_DEPTH));
        end
    end

    a_count_in_range: assert property (@(posedge clk) disable iff (rst)
        (count_calc >= 0) && (count_calc <= IQ_DEPTH));

    assign iq.iss_valid   = iss_valid;
    assign iq.iss_payload = sel.payload;
    assign iq.iss_src1    = sel.src1;
    assign iq.iss_src2    = sel.src2;
    assign iq.iss_dst     = sel.dst;
    assign iq.iss_br_mask = sel.br_mask;
    assign iq.iq_full     = full_q;
    assign iq.iq_count    = count_q;

endmodule
`default_nettype wire
